bvshl_inv_checker: RTL and testbench

- Forward-direction counterpart of the bvshl inverse Skolem-function blocks, which produce a witness x from (s, t).
- This block takes s, t and a candidate x from such a function and evaluates the constraint bvshl(x, s) == t, where x is operand 0 and s is the shift amount.
- It searches all 2^W values of x, one per cycle, to decide whether any solution exists.
- It reports whether the candidate is a correct Skolem output, and keeps pass/fail statistics.
- It sits in the Skolem-function verification harness, between the stimulus generator and the scoreboard.

---
 rtl/bvshl_inv_pkg.sv | 24 ++
 rtl/bvshl_unit.sv | 26 ++
 rtl/bvshl_inv_checker.sv | 151 +++++++++++++++
 tb/tb_bvshl_inv_checker.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/bvshl_inv_pkg.sv
// Shared definitions for the bvshl inverse-function checker.
// Contents:
//   W_DEFAULT - default bit width of s, t and x
//   state_t   - checker FSM states
//   bvshl_w   - reference left shift truncated to w bits; any shift
//               amount >= w gives 0. The harness scoreboard reuses it.
package bvshl_inv_pkg;

  localparam int unsigned W_DEFAULT = 4;

  typedef enum logic [1:0] {IDLE, EVAL, SEARCH, RESP} state_t;

  // Operands are carried at 32 bits so that one function serves every
  // width up to 32. The mask removes whatever was shifted past bit w-1.
  function automatic logic [31:0] bvshl_w(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input int unsigned w);
    logic [31:0] mask;
    mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    if (b >= w) return 32'd0;
    return (a << b) & mask;
  endfunction

endpackage

// File: rtl/bvshl_unit.sv
// Combinational W-bit left shifter with an equality compare.
// Ports:
//   a  - value being shifted (operand 0)
//   b  - shift amount
//   t  - target value
//   eq - high when bvshl(a, b) == t
module bvshl_unit
  import bvshl_inv_pkg::*;
#(
  parameter int unsigned W = W_DEFAULT
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] t,
  output logic         eq
);

  logic [W-1:0] shifted;

  // Only W bits are kept, so any carry-out from the shift is discarded.
  always_comb begin
    shifted = W'(bvshl_w(32'(a), 32'(b), W));
    eq      = (shifted == t);
  end

endmodule

// File: rtl/bvshl_inv_checker.sv
// Forward checker for the bvshl inverse Skolem functions.
// It takes (s, t, x) and checks the candidate x against bvshl(x, s) == t.
// It then searches every y in [0, 2^W-1], one per cycle, to find out
// whether any solution exists. It reports the verdict and keeps saturating
// pass/fail counters.
// Ports:
//   clk, rst_n          - clock (rising edge), async active-low reset
//   in_valid, in_ready  - request handshake; s, t, x are latched on acceptance
//   s, t, x             - shift amount, target, candidate witness
//   out_valid, out_ready- result handshake
//   pass                - bvshl(x, s) == t
//   sat                 - some y satisfies bvshl(y, s) == t
//   cand_ok             - pass | ~sat (candidate acceptable)
//   first_x             - smallest satisfying y, 0 when unsatisfiable
//   clr_stats           - synchronous clear of the counters
//   n_checked, n_fail   - completed results / results with cand_ok = 0
module bvshl_inv_checker
  import bvshl_inv_pkg::*;
#(
  parameter int unsigned W  = W_DEFAULT,
  parameter int unsigned CW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  s,
  input  logic [W-1:0]  t,
  input  logic [W-1:0]  x,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          pass,
  output logic          sat,
  output logic          cand_ok,
  output logic [W-1:0]  first_x,
  input  logic          clr_stats,
  output logic [CW-1:0] n_checked,
  output logic [CW-1:0] n_fail
);

  state_t state, state_nx;

  logic [W-1:0] s_q, t_q, x_q;
  logic [W-1:0] y;
  logic         cand_eq;
  logic         y_eq;
  logic         y_last;
  logic         out_hs;

  // One shifter judges the latched candidate and the other walks the
  // search index. Both share the latched shift amount and target.
  bvshl_unit #(.W(W)) u_cand (
    .a  (x_q),
    .b  (s_q),
    .t  (t_q),
    .eq (cand_eq)
  );

  bvshl_unit #(.W(W)) u_search (
    .a  (y),
    .b  (s_q),
    .t  (t_q),
    .eq (y_eq)
  );

  assign y_last = &y;
  assign out_hs = out_valid & out_ready;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic. SEARCH exits early on the first match, or after the
  // last index when nothing matched.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (in_valid)          state_nx = EVAL;
      EVAL:                           state_nx = SEARCH;
      SEARCH:  if (y_eq || y_last)    state_nx = RESP;
      RESP:    if (out_ready)         state_nx = IDLE;
      default:                        state_nx = IDLE;
    endcase
  end

  // Output decode. cand_ok is forced low outside RESP so that it reads 0
  // after reset even though pass and sat are both 0 then.
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == RESP);
    cand_ok   = (state == RESP) & (pass | ~sat);
  end

  // Request latch, candidate verdict and search datapath. The results hold
  // their values in RESP, which keeps them stable under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q     <= '0;
      t_q     <= '0;
      x_q     <= '0;
      y       <= '0;
      pass    <= 1'b0;
      sat     <= 1'b0;
      first_x <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            s_q <= s;
            t_q <= t;
            x_q <= x;
          end
        end
        EVAL: begin
          pass <= cand_eq;
          y    <= '0;
        end
        SEARCH: begin
          if (y_eq) begin
            sat     <= 1'b1;
            first_x <= y;
          end else if (y_last) begin
            sat     <= 1'b0;
            first_x <= '0;
          end else begin
            y <= y + W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Saturating statistics, updated on the result handshake. A clear in
  // the same cycle takes priority over the increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_checked <= '0;
      n_fail    <= '0;
    end else if (clr_stats) begin
      n_checked <= '0;
      n_fail    <= '0;
    end else if (out_hs) begin
      if (n_checked != {CW{1'b1}}) n_checked <= n_checked + CW'(1);
      if (!cand_ok && (n_fail != {CW{1'b1}})) n_fail <= n_fail + CW'(1);
    end
  end

endmodule

// File: tb/tb_bvshl_inv_checker.sv
// Directed testbench for bvshl_inv_checker. A second instance with CW=2
// shares all inputs so that counter saturation can be reached quickly.
module tb_bvshl_inv_checker;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [3:0] s = '0, t = '0, x = '0;
  logic       out_ready = 1'b0;
  logic       clr_stats = 1'b0;

  logic        in_ready, out_valid, pass, sat, cand_ok;
  logic [3:0]  first_x;
  logic [15:0] n_checked, n_fail;

  logic        in_ready2, out_valid2, pass2, sat2, cand_ok2;
  logic [3:0]  first_x2;
  logic [1:0]  n_checked2, n_fail2;

  int checks = 0;
  int passes = 0;

  typedef struct {
    logic [3:0] s, t, x;
    logic       p, st;
    logic [3:0] fx;
    logic       ok;
    int         cyc;
  } vec_t;

  bvshl_inv_checker #(.W(4), .CW(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .s(s), .t(t), .x(x), .out_valid(out_valid), .out_ready(out_ready),
    .pass(pass), .sat(sat), .cand_ok(cand_ok), .first_x(first_x),
    .clr_stats(clr_stats), .n_checked(n_checked), .n_fail(n_fail)
  );

  bvshl_inv_checker #(.W(4), .CW(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
    .s(s), .t(t), .x(x), .out_valid(out_valid2), .out_ready(out_ready),
    .pass(pass2), .sat(sat2), .cand_ok(cand_ok2), .first_x(first_x2),
    .clr_stats(clr_stats), .n_checked(n_checked2), .n_fail(n_fail2)
  );

  always #5 clk = ~clk;

  // Hard stop in case something deadlocks despite the bounded waits
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time exceeded, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Waits (bounded) for in_ready, then presents one request. It returns at
  // the falling edge of cycle 1, where the acceptance edge is cycle 0.
  task automatic applyStimulus(input logic [3:0] si, ti, xi);
    int n = 0;
    while (in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (in_ready !== 1'b1) begin
      checks++;
      $display("[TB] FAIL accept_wait: in_ready=%b expected 1", in_ready);
    end
    s = si; t = ti; x = xi;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Counts cycles until out_valid, starting from the given cycle number
  task automatic waitResult(input int start, output int cyc);
    cyc = start;
    while (out_valid !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    if (out_valid !== 1'b1) begin
      checks++;
      $display("[TB] FAIL result_wait: out_valid=%b expected 1", out_valid);
    end
  endtask

  // One-cycle result handshake, optionally with clr_stats in the same cycle
  task automatic handshake(input logic clr);
    out_ready = 1'b1;
    clr_stats = clr;
    @(negedge clk);
    out_ready = 1'b0;
    clr_stats = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) $display("[TB] FAIL rst_in_ready: got %b expected 1", in_ready); else passes++;
    checks++; if (out_valid !== 1'b0) $display("[TB] FAIL rst_out_valid: got %b expected 0", out_valid); else passes++;
    checks++; if ({pass, sat, cand_ok} !== 3'b000) $display("[TB] FAIL rst_flags: got %b expected 000", {pass, sat, cand_ok}); else passes++;
    checks++; if (first_x !== 4'd0) $display("[TB] FAIL rst_first_x: got %0d expected 0", first_x); else passes++;
    checks++; if (n_checked !== 16'd0 || n_fail !== 16'd0) $display("[TB] FAIL rst_counters: got %0d/%0d expected 0/0", n_checked, n_fail); else passes++;
  endtask

  // Directed vectors with hand-computed results and latencies
  task automatic test_directed();
    vec_t vecs [5];
    int cyc;
    int exp_chk = 0, exp_fail = 0;
    vecs[0] = '{4'd1, 4'd6, 4'd3, 1'b1, 1'b1, 4'd3, 1'b1, 6};
    vecs[1] = '{4'd1, 4'd5, 4'd2, 1'b0, 1'b0, 4'd0, 1'b1, 18};
    vecs[2] = '{4'd0, 4'd7, 4'd6, 1'b0, 1'b1, 4'd7, 1'b0, 10};
    vecs[3] = '{4'd5, 4'd1, 4'd1, 1'b0, 1'b0, 4'd0, 1'b1, 18};
    vecs[4] = '{4'd5, 4'd0, 4'd9, 1'b1, 1'b1, 4'd0, 1'b1, 3};
    for (int i = 0; i < 5; i++) begin
      applyStimulus(vecs[i].s, vecs[i].t, vecs[i].x);
      waitResult(1, cyc);
      checks++; if (cyc !== vecs[i].cyc) $display("[TB] FAIL vec%0d_latency: got %0d expected %0d", i, cyc, vecs[i].cyc); else passes++;
      checks++; if (pass !== vecs[i].p) $display("[TB] FAIL vec%0d_pass: got %b expected %b", i, pass, vecs[i].p); else passes++;
      checks++; if (sat !== vecs[i].st) $display("[TB] FAIL vec%0d_sat: got %b expected %b", i, sat, vecs[i].st); else passes++;
      checks++; if (first_x !== vecs[i].fx) $display("[TB] FAIL vec%0d_first_x: got %0d expected %0d", i, first_x, vecs[i].fx); else passes++;
      checks++; if (cand_ok !== vecs[i].ok) $display("[TB] FAIL vec%0d_cand_ok: got %b expected %b", i, cand_ok, vecs[i].ok); else passes++;
      exp_chk++;
      if (!vecs[i].ok) exp_fail++;
      handshake(1'b0);
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("[TB] FAIL vec%0d_release: got out_valid=%b in_ready=%b expected 0/1", i, out_valid, in_ready); else passes++;
      checks++; if (n_checked !== 16'(exp_chk) || n_fail !== 16'(exp_fail)) $display("[TB] FAIL vec%0d_counters: got %0d/%0d expected %0d/%0d", i, n_checked, n_fail, exp_chk, exp_fail); else passes++;
    end
  endtask

  // Results held under backpressure; a stray in_valid during SEARCH is ignored
  task automatic test_backpressure();
    int cyc;
    applyStimulus(4'd2, 4'd4, 4'd1);
    @(negedge clk);
    s = 4'd0; t = 4'd15; x = 4'd0;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    waitResult(3, cyc);
    checks++; if (cyc !== 4) $display("[TB] FAIL bp_latency: got %0d expected 4", cyc); else passes++;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || {pass, sat, cand_ok} !== 3'b111 || first_x !== 4'd1)
        $display("[TB] FAIL bp_hold%0d: got ov=%b ir=%b flags=%b fx=%0d expected 1 0 111 1", i, out_valid, in_ready, {pass, sat, cand_ok}, first_x);
      else passes++;
      checks++; if (n_checked !== 16'd5 || n_fail !== 16'd1) $display("[TB] FAIL bp_counters%0d: got %0d/%0d expected 5/1", i, n_checked, n_fail); else passes++;
      @(negedge clk);
    end
    handshake(1'b0);
    checks++; if (n_checked !== 16'd6 || n_fail !== 16'd1) $display("[TB] FAIL bp_counters_after: got %0d/%0d expected 6/1", n_checked, n_fail); else passes++;
    repeat (5) @(negedge clk);
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("[TB] FAIL bp_stray_ignored: got out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready); else passes++;
  endtask

  // Reset asserted while the search index is at y=2 drops the request
  task automatic test_reset_mid();
    applyStimulus(4'd1, 4'd6, 4'd3);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || {pass, sat, cand_ok} !== 3'b000 || first_x !== 4'd0 || n_checked !== 16'd0 || n_fail !== 16'd0)
      $display("[TB] FAIL midrst_values: got ir=%b ov=%b flags=%b fx=%0d cnt=%0d/%0d expected 1 0 000 0 0/0", in_ready, out_valid, {pass, sat, cand_ok}, first_x, n_checked, n_fail);
    else passes++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) $display("[TB] FAIL midrst_in_ready: got %b expected 1", in_ready); else passes++;
    repeat (8) @(negedge clk);
    checks++; if (out_valid !== 1'b0 || n_checked !== 16'd0) $display("[TB] FAIL midrst_dropped: got out_valid=%b n_checked=%0d expected 0/0", out_valid, n_checked); else passes++;
  endtask

  // Five failing requests saturate the 2-bit counter; clear beats increment
  task automatic test_saturation();
    int cyc;
    int exp;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(4'd0, 4'd7, 4'd6);
      waitResult(1, cyc);
      handshake(1'b0);
      exp = (i + 1 > 3) ? 3 : i + 1;
      checks++; if (n_fail2 !== 2'(exp) || n_checked2 !== 2'(exp)) $display("[TB] FAIL sat_cw2_%0d: got %0d/%0d expected %0d/%0d", i, n_checked2, n_fail2, exp, exp); else passes++;
    end
    checks++; if (n_fail !== 16'd5) $display("[TB] FAIL sat_cw16_fail: got %0d expected 5", n_fail); else passes++;
    applyStimulus(4'd0, 4'd7, 4'd6);
    waitResult(1, cyc);
    handshake(1'b1);
    checks++; if (n_fail2 !== 2'd0 || n_checked2 !== 2'd0) $display("[TB] FAIL clr_cw2: got %0d/%0d expected 0/0", n_checked2, n_fail2); else passes++;
    checks++; if (n_fail !== 16'd0 || n_checked !== 16'd0) $display("[TB] FAIL clr_cw16: got %0d/%0d expected 0/0", n_checked, n_fail); else passes++;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid();
    test_saturation();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
